// File: rtl/count_pkg.sv
// ============================================================================
// count_pkg : shared state encoding and width constants for the count stage
// Revision  : 1.0
// ============================================================================
`default_nettype none

package count_pkg;

    localparam int COUNT_WIDTH_DEF = 16;
    localparam int PRESCALE_W      = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } count_state_e;

endpackage

`default_nettype wire

// File: rtl/count_prescaler.sv
// ============================================================================
// count_prescaler : 8-bit enable divider with clear, strobes tick every
//                   prescale+1 enabled cycles
// Revision        : 1.0
// ============================================================================
`default_nettype none

module count_prescaler
    import count_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] r_cnt;

    assign tick = en && !clr && (r_cnt == prescale);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr || tick) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + PRESCALE_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/count_reg.sv
// ============================================================================
// count_reg : registered programmable count stage (IDLE/RUN/DONE) with load,
//             preset, terminal-count pulse and sticky interrupt.
//             Optional prescaler: define COUNT_REG_PRESCALE_EN.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module count_reg
    import count_pkg::*;
#(
    parameter int WIDTH = COUNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  oneshot,
    input  logic                  cnt_en,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  preset,
    input  logic [WIDTH-1:0]      period,
    input  logic                  irq_ack,
`ifdef COUNT_REG_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] prescale,
`endif
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  irq,
    output logic                  busy
);

    count_state_e     r_state;
    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_irq;
    logic             r_busy;

    count_state_e     w_state_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_adv;
    logic             w_hit;
    logic             w_pre_tick;

`ifdef COUNT_REG_PRESCALE_EN
    logic w_pre_clr;
    logic w_pre_en;

    assign w_pre_clr = start | stop | load | preset;
    assign w_pre_en  = (r_state == RUN) && cnt_en;

    count_prescaler u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (w_pre_clr),
        .en       (w_pre_en),
        .prescale (prescale),
        .tick     (w_pre_tick)
    );
`else
    assign w_pre_tick = 1'b1;
`endif

    // stop freezes the count, so it also blocks any advance or terminal hit
    assign w_adv = (r_state == RUN) && cnt_en && w_pre_tick && !stop;
    assign w_hit = w_adv && !preset && !load && (r_count == period);

    always_comb begin
        w_state_nxt = r_state;
        if (stop) begin
            w_state_nxt = IDLE;
        end else if (start && (r_state != RUN)) begin
            w_state_nxt = RUN;
        end else if (w_hit && oneshot) begin
            w_state_nxt = DONE;
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        if (preset) begin
            w_count_nxt = '1;
        end else if (load) begin
            w_count_nxt = load_val;
        end else if (start && !stop && (r_state == DONE)) begin
            w_count_nxt = '0;
        end else if (w_adv) begin
            if (r_count != period) begin
                w_count_nxt = r_count + WIDTH'(1);
            end else if (!oneshot) begin
                w_count_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_count <= '0;
            r_tc    <= 1'b0;
            r_irq   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_tc    <= w_hit;
            r_irq   <= w_hit | (r_irq & ~irq_ack);
            r_busy  <= (w_state_nxt == RUN);
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign irq   = r_irq;
    assign busy  = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_count_reg.sv
// ============================================================================
// tb_count_reg : directed-vector scoreboard bench for count_reg
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_count_reg;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        oneshot;
    logic        cnt_en;
    logic        load;
    logic [15:0] load_val;
    logic        preset;
    logic [15:0] period;
    logic        irq_ack;
`ifdef COUNT_REG_PRESCALE_EN
    logic [7:0]  prescale;
`endif
    logic [15:0] count;
    logic        tc;
    logic        irq;
    logic        busy;

    typedef struct {
        logic [15:0] count;
        logic        tc;
        logic        irq;
        logic        busy;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    count_reg #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .oneshot  (oneshot),
        .cnt_en   (cnt_en),
        .load     (load),
        .load_val (load_val),
        .preset   (preset),
        .period   (period),
        .irq_ack  (irq_ack),
`ifdef COUNT_REG_PRESCALE_EN
        .prescale (prescale),
`endif
        .count    (count),
        .tc       (tc),
        .irq      (irq),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs after the edge that samples the current inputs
    task automatic tick(input string tag, input logic [15:0] c,
                        input logic t, input logic i, input logic b);
        exp_t e;
        @(posedge clk);
        e.count = c;
        e.tc    = t;
        e.irq   = i;
        e.busy  = b;
        e.tag   = tag;
        q.push_back(e);
        #1;
        start   = 1'b0;
        stop    = 1'b0;
        load    = 1'b0;
        preset  = 1'b0;
        irq_ack = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [18:0] act, input logic [18:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {count,tc,irq,busy}=%h, expected %h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_checks++;
            if ({count, tc, irq, busy} !== {e.count, e.tc, e.irq, e.busy}) begin
                n_fail++;
                $display("FAIL %s: got count=%h tc=%b irq=%b busy=%b, expected count=%h tc=%b irq=%b busy=%b",
                         e.tag, count, tc, irq, busy, e.count, e.tc, e.irq, e.busy);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; oneshot = 1'b0; cnt_en = 1'b0;
        load = 1'b0; load_val = 16'h0; preset = 1'b0; period = 16'h0; irq_ack = 1'b0;
`ifdef COUNT_REG_PRESCALE_EN
        prescale = 8'd0;
`endif
        repeat (2) @(posedge clk);
        #1 chk("reset_vals", {count, tc, irq, busy}, 19'h0);
        @(negedge clk) rst_n = 1'b1;

        // periodic, period 3
        period = 16'd3; cnt_en = 1'b1; start = 1'b1;
        tick("per_start", 16'h0, 0, 0, 1);
        tick("per_c1",    16'h1, 0, 0, 1);
        tick("per_c2",    16'h2, 0, 0, 1);
        tick("per_c3",    16'h3, 0, 0, 1);
        tick("per_wrap",  16'h0, 1, 1, 1);
        tick("per_c1b",   16'h1, 0, 1, 1);
        tick("per_c2b",   16'h2, 0, 1, 1);
        irq_ack = 1'b1;
        tick("per_ack",   16'h3, 0, 0, 1);
        irq_ack = 1'b1;
        tick("tc_ack_same", 16'h0, 1, 1, 1);
        stop = 1'b1;
        tick("stop_run",  16'h0, 0, 1, 0);
        irq_ack = 1'b1;
        tick("ack_idle",  16'h0, 0, 0, 0);
        start = 1'b1; stop = 1'b1;
        tick("start_stop", 16'h0, 0, 0, 0);

        // one-shot, period 2
        oneshot = 1'b1; period = 16'd2; start = 1'b1;
        tick("os_start",   16'h0, 0, 0, 1);
        tick("os_c1",      16'h1, 0, 0, 1);
        tick("os_c2",      16'h2, 0, 0, 1);
        tick("os_done",    16'h2, 1, 1, 0);
        tick("os_hold",    16'h2, 0, 1, 0);
        start = 1'b1;
        tick("os_restart", 16'h0, 0, 1, 1);
        tick("os_c1r",     16'h1, 0, 1, 1);
        stop = 1'b1;
        tick("os_stop",    16'h1, 0, 1, 0);
        irq_ack = 1'b1;
        tick("os_ack",     16'h1, 0, 0, 0);

        // load beyond period, wrap without early tc
        oneshot = 1'b0; period = 16'd1; load_val = 16'hFFFE; start = 1'b1; load = 1'b1;
        tick("ld_start", 16'hFFFE, 0, 0, 1);
        tick("ld_ffff",  16'hFFFF, 0, 0, 1);
        tick("ld_wrap",  16'h0000, 0, 0, 1);
        tick("ld_c1",    16'h0001, 0, 0, 1);
        tick("ld_tc",    16'h0000, 1, 1, 1);
        cnt_en = 1'b0;
        tick("en_hold",  16'h0000, 0, 1, 1);
        cnt_en = 1'b1; preset = 1'b1; load = 1'b1; load_val = 16'h1234;
        tick("preset_load", 16'hFFFF, 0, 1, 1);
        tick("pl_wrap",  16'h0000, 0, 1, 1);
        period = 16'd0;
        tick("p0_a",     16'h0000, 1, 1, 1);
        tick("p0_b",     16'h0000, 1, 1, 1);
        load = 1'b1; load_val = 16'h0000;
        tick("p0_load",  16'h0000, 0, 1, 1);
        cnt_en = 1'b0; load = 1'b1; load_val = 16'h0123;
        tick("ld_0123",  16'h0123, 0, 1, 1);

        // asynchronous reset mid-RUN
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {count, tc, irq, busy}, 19'h0);
        @(negedge clk) rst_n = 1'b1;
        cnt_en = 1'b1; period = 16'd1;
        tick("rst_idle", 16'h0, 0, 0, 0);

`ifdef COUNT_REG_PRESCALE_EN
        prescale = 8'd2; start = 1'b1;
        tick("ps_start", 16'h0, 0, 0, 1);
        tick("ps_t1",    16'h0, 0, 0, 1);
        tick("ps_t2",    16'h0, 0, 0, 1);
        tick("ps_t3",    16'h1, 0, 0, 1);
        tick("ps_t4",    16'h1, 0, 0, 1);
        load = 1'b1; load_val = 16'h0;
        tick("ps_load",  16'h0, 0, 0, 1);
        tick("ps_t6",    16'h0, 0, 0, 1);
        tick("ps_t7",    16'h0, 0, 0, 1);
        tick("ps_t8",    16'h1, 0, 0, 1);
        tick("ps_t9",    16'h1, 0, 0, 1);
        tick("ps_t10",   16'h1, 0, 0, 1);
        tick("ps_tc",    16'h0, 1, 1, 1);
`else
        start = 1'b1;
        tick("post_start", 16'h0, 0, 0, 1);
        tick("post_c1",    16'h1, 0, 0, 1);
        tick("post_tc",    16'h0, 1, 1, 1);
`endif

        repeat (3) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
